// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache state, address split and frame layout.
// Tag field is sized for the smallest legal cache (two frames).
package cpu_types_pkg;

    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_TAGW  = 29;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        logic [31:0]            data;
    } icache_frame_t;

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with
// same-cycle hits and a blocking single-word refill.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NSETS = ICACHE_NSETS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IW = $clog2(NSETS);

    icache_state_t state, next_state;
    icache_frame_t frames [NSETS];
    icache_frame_t rd;

    logic [31:0]            miss_addr;
    logic [IW-1:0]          req_idx, fill_idx;
    logic [ICACHE_TAGW-1:0] req_tag, fill_tag;
    logic                   miss_start, fill;

    assign req_idx  = imemaddr[IW+1:2];
    assign fill_idx = miss_addr[IW+1:2];
    assign req_tag  = ICACHE_TAGW'(imemaddr >> (IW + 2));
    assign fill_tag = ICACHE_TAGW'(miss_addr >> (IW + 2));
    assign rd       = frames[req_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= next_state;
            if (miss_start) begin
                miss_addr <= imemaddr;
            end
        end
    end

    // Tag/data are written on every fill; only valid decides usability,
    // so an invalidate racing a fill simply leaves the frame unusable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NSETS; i++) begin
                frames[i].valid <= 1'b0;
            end
        end else begin
            if (fill) begin
                frames[fill_idx].tag  <= fill_tag;
                frames[fill_idx].data <= iload;
            end
            if (inv) begin
                for (int i = 0; i < NSETS; i++) begin
                    frames[i].valid <= 1'b0;
                end
            end else if (fill) begin
                frames[fill_idx].valid <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        fill       = 1'b0;
        unique case (state)
            IDLE: begin
                if (imemREN && !inv) begin
                    if (rd.valid && (rd.tag == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = rd.data;
                    end else begin
                        miss_start = 1'b1;
                        next_state = MISS;
                    end
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    sat_counter u_hit (
        .CLK   (CLK),
        .RST   (RST),
        .en    (ihit),
        .count (hit_count)
    );

    sat_counter u_miss (
        .CLK   (CLK),
        .RST   (RST),
        .en    (miss_start),
        .count (miss_count)
    );

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a memory model answers refills and a
// scoreboard checks every hit word against queued expectations.
module tb_icache;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        inv;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        inv_main;
    logic        inv_fill;
    bit          inv_at_fill;
    int          lat;

    int n_checks;
    int n_fail;

    logic [31:0] expq[$];

    assign inv = inv_main | inv_fill;

    icache #(.NSETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .inv        (inv),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: `lat` busy cycles then data = addr ^ 0x8C220044.
    initial begin
        int  wcnt;
        bit  inv_used;
        wcnt     = 0;
        inv_used = 1'b0;
        iwait    = 1'b1;
        iload    = '0;
        inv_fill = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            inv_fill = 1'b0;
            if (!inv_at_fill) inv_used = 1'b0;
            if (iREN) begin
                if (wcnt >= lat) begin
                    iwait = 1'b0;
                    iload = iaddr ^ 32'h8C22_0044;
                    wcnt  = 0;
                    if (inv_at_fill && !inv_used) begin
                        inv_fill = 1'b1;
                        inv_used = 1'b1;
                    end
                end else begin
                    iwait = 1'b1;
                    iload = '0;
                    wcnt++;
                end
            end else begin
                iwait = 1'b1;
                iload = '0;
                wcnt  = 0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (ihit) begin
            if (expq.size() == 0) begin
                check("unexpected_hit", imemload, 32'hxxxx_xxxx);
            end else begin
                check("hit_data", imemload, expq.pop_front());
            end
        end
    end

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input int exp_ren, input int exp_cyc,
                          input string nm);
        int cyc;
        int ren;
        int bad;
        bit got;
        @(posedge CLK);
        #1;
        imemREN  = 1'b1;
        imemaddr = a;
        expq.push_back(d);
        cyc = 0;
        ren = 0;
        bad = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge CLK);
            if (ihit) begin
                got = 1'b1;
            end else begin
                if (iREN) begin
                    ren++;
                    if (iaddr != a) bad++;
                end
                cyc++;
            end
        end
        check({nm, "_hit"}, 32'(got), 32'd1);
        check({nm, "_iren_cycles"}, 32'(ren), 32'(exp_ren));
        check({nm, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({nm, "_iaddr_bad"}, 32'(bad), 32'd0);
        if (!got) void'(expq.pop_back());
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        RST         = 1'b1;
        imemREN     = 1'b0;
        imemaddr    = '0;
        inv_main    = 1'b0;
        inv_at_fill = 1'b0;
        lat         = 3;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iREN", 32'(iREN), 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        // cold miss, three busy cycles
        access(32'h40, 32'h8C22_0004, 4, 5, "cold");
        check("cold_miss_count", miss_count, 32'd1);
        check("cold_hit_count", hit_count, 32'd1);

        // conflict eviction on index 0
        do_reset();
        lat = 1;
        access(32'h00, 32'h8C22_0044, 2, 3, "fill0");
        access(32'h40, 32'h8C22_0004, 2, 3, "fill40");
        access(32'h00, 32'h8C22_0044, 2, 3, "refetch0");
        check("evict_miss_count", miss_count, 32'd3);
        access(32'h00, 32'h8C22_0044, 0, 0, "hit0");
        check("evict_hit_count", hit_count, 32'd4);

        // other frames undisturbed, then invalidate
        access(32'h10, 32'h8C22_0054, 2, 3, "fill10");
        access(32'h00, 32'h8C22_0044, 0, 0, "keep0");
        access(32'h10, 32'h8C22_0054, 0, 0, "hit10");
        @(posedge CLK);
        #1;
        imemREN  = 1'b1;
        imemaddr = 32'h10;
        inv_main = 1'b1;
        @(negedge CLK);
        check("inv_cycle_ihit", 32'(ihit), 32'd0);
        check("inv_cycle_iREN", 32'(iREN), 32'd0);
        @(posedge CLK);
        #1;
        inv_main = 1'b0;
        imemREN  = 1'b0;
        access(32'h10, 32'h8C22_0054, 2, 3, "postinv10");
        access(32'h00, 32'h8C22_0044, 2, 3, "postinv0");
        check("inv_miss_count", miss_count, 32'd6);

        // invalidate coinciding with fill completion
        inv_at_fill = 1'b1;
        access(32'h20, 32'h8C22_0064, 4, 6, "invfill20");
        inv_at_fill = 1'b0;
        check("invfill_miss_count", miss_count, 32'd8);
        access(32'h20, 32'h8C22_0064, 0, 0, "hit20");

        // hit counter saturation
        @(negedge CLK);
        force dut.u_hit.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_hit.count;
        #1;
        check("sat_preload", hit_count, 32'hFFFF_FFFE);
        access(32'h20, 32'h8C22_0064, 0, 0, "sat1");
        check("sat_first", hit_count, 32'hFFFF_FFFF);
        access(32'h20, 32'h8C22_0064, 0, 0, "sat2");
        check("sat_hold", hit_count, 32'hFFFF_FFFF);

        // reset in the middle of a miss
        lat = 5;
        @(posedge CLK);
        #1;
        imemREN  = 1'b1;
        imemaddr = 32'h30;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("midmiss_iREN", 32'(iREN), 32'd1);
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("postrst_iREN", 32'(iREN), 32'd0);
        check("postrst_iaddr", iaddr, 32'd0);
        check("postrst_hit_count", hit_count, 32'd0);
        check("postrst_miss_count", miss_count, 32'd0);
        lat = 1;
        access(32'h20, 32'h8C22_0064, 2, 3, "rst20");
        access(32'h40, 32'h8C22_0004, 2, 3, "rst40");
        check("rst_final_miss_count", miss_count, 32'd2);

        @(negedge CLK);
        check("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: NSETS, default 16, number of direct-mapped frames; power of two, 2..64.
REQ-002 Port: CLK  input  1  rising-edge clock; sole clock of the block.
REQ-003 Port: RST  input  1  reset; synchronous, active-high.
REQ-004 Port: imemREN  input  1  datapath instruction read request.
REQ-005 Port: imemaddr  input  32  datapath fetch byte address, word-aligned.
REQ-006 Port: ihit  output  1  imemload is valid for imemaddr this cycle.
REQ-007 Port: imemload  output  32  instruction word returned to datapath.
REQ-008 Port: inv  input  1  invalidate all frames.
REQ-009 Port: iREN  output  1  memory-controller read request.
REQ-010 Port: iaddr  output  32  memory-controller read byte address.
REQ-011 Port: iwait  input  1  memory controller busy; data not yet valid.
REQ-012 Port: iload  input  32  memory-controller read data.
REQ-013 Port: hit_count  output  32  saturating count of hit cycles.
REQ-014 Port: miss_count  output  32  saturating count of misses.

Function
REQ-015 Address split: bits[1:0] byte offset (ignored), next log2(NSETS) bits index, remaining upper bits tag.
REQ-016 Each frame holds valid (1 bit), tag, data (32 bits); one word per block.
REQ-017 FSM states: IDLE, MISS.
REQ-018 IDLE: ihit = imemREN and frame[index].valid and tag match; combinational, same cycle; imemload = frame[index].data when ihit, else 0.
REQ-019 IDLE, imemREN=1, not hit, inv=0: latch imemaddr into miss_addr, go to MISS, increment miss_count.
REQ-020 MISS: iREN=1, iaddr=miss_addr; ihit=0 regardless of imemaddr.
REQ-021 MISS, iwait=0: write frame[miss_addr index] = {valid=1, tag, iload}; go to IDLE; requested word hits on the following cycle (miss latency = memory latency + 1 cycle).
REQ-022 MISS, iwait=1: hold state, iREN, iaddr.
REQ-023 IDLE: iREN=0, iaddr=0.
REQ-024 imemREN dropping or imemaddr changing during MISS: fill completes using miss_addr; no abort.
REQ-025 inv=1: clear all valid bits at next edge; ihit=0 in that cycle; in MISS, fill is still awaited but frame is left invalid; inv in same cycle as fill completion: invalid wins.
REQ-026 hit_count increments every cycle ihit=1; both counters saturate at 0xFFFFFFFF, no wrap.
REQ-027 Store/fill to one index never disturbs other frames.

Reset
REQ-028 RST=1 at a clock edge: state=IDLE, all valid=0, miss_addr=0, hit_count=0, miss_count=0; data/tag arrays need no reset.
REQ-029 Reset mid-MISS: abandon fill; iREN=0 from the cycle after the reset edge; late iload ignored.
REQ-030 Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0, counters 0.

Structure
REQ-031 Shared package cpu_types_pkg holds: icache state enum, icachef_t address-split struct, icache_frame_t struct, ICACHE_NSETS default constant.
REQ-032 One sub-module, sat_counter (32-bit saturating counter with enable and sync reset), instantiated twice for hit_count and miss_count.
REQ-033 Frame array is flops; no SRAM macro.

Verification
REQ-034 Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> iREN=1/iaddr=0x40 for 4 cycles, ihit=1 imemload=0x8C220004 on cycle 5, miss_count=1.
REQ-035 Conflict eviction: fill 0x00000000 then 0x00000040 (same index, NSETS=16) -> refetch of 0x0 misses again, miss_count=3.
REQ-036 Invalidate: hit on 0x00000010, pulse inv one cycle -> next access to 0x10 misses, iREN=1.
REQ-037 Inv during fill: inv=1 on the iwait=0 cycle of a miss to 0x20 -> returns to IDLE, next access to 0x20 misses again.
REQ-038 Reset mid-miss: RST=1 while MISS with iwait=1 -> iREN=0 next cycle, counters 0, all subsequent accesses miss.
REQ-039 Saturation: force hit_count to 0xFFFFFFFE, two hit cycles -> hit_count holds 0xFFFFFFFF.
